pc_fetch_ctrl: RTL and testbench

Fetch-side PC sequencer. Owns the architectural fetch PC and generates the next-PC value and stall/flush controls for the downstream pc_pipeline registers (IF/ID, ID/EX). It merges the sequential increment, branch/jump redirects from EX and hazard stalls into one ordered PC stream. A redirect that arrives while the pipeline is stalled is held as pending and applied when the stall releases.

---
 rtl/riscv_pkg.sv | 15 +
 rtl/pc_redirect_buf.sv | 33 +++
 rtl/pc_fetch_ctrl.sv | 167 ++++++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared fetch-side constants and the fetch FSM state encoding.
package riscv_pkg;

    localparam int RV_XLEN = 32;
    localparam logic [31:0] RV_RESET_PC = 32'h0000_0000;
    localparam int RV_INSTR_BYTES = 4;
    localparam int RV_FLUSH_CYCLES = 2;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t ST_RUN   = 2'd0;
    localparam fetch_state_t ST_FLUSH = 2'd1;
    localparam fetch_state_t ST_HOLD  = 2'd2;

endpackage

// File: rtl/pc_redirect_buf.sv
// Pending redirect store: one target register plus its valid bit.
// Capture and overwrite share one input; the newest capture always wins.
module pc_redirect_buf #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_capture,
    input  logic            i_clear,
    input  logic [XLEN-1:0] i_target,
    output logic            o_valid,
    output logic [XLEN-1:0] o_target
);

    logic            r_valid;
    logic [XLEN-1:0] r_target;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid  <= 1'b0;
            r_target <= '0;
        end else if (i_capture) begin
            r_valid  <= 1'b1;
            r_target <= i_target;
        end else if (i_clear) begin
            r_valid  <= 1'b0;
        end
    end

    assign o_valid  = r_valid;
    assign o_target = r_target;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch PC sequencer: sequential increment, EX redirects, stall hold and
// pending-redirect replay. Optional PC_MISALIGN_CHECK_EN aligns redirect targets.
module pc_fetch_ctrl
    import riscv_pkg::*;
#(
    parameter int          XLEN         = RV_XLEN,
    parameter logic [31:0] RESET_PC     = RV_RESET_PC,
    parameter int          INSTR_BYTES  = RV_INSTR_BYTES,
    parameter int          FLUSH_CYCLES = RV_FLUSH_CYCLES
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_in,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_next,
    output logic            pc_stall,
    output logic            flush,
    output logic            fetch_valid,
    output logic            redirect_pending,
    output logic            misalign_err
);

    localparam logic [XLEN-1:0] INCR     = XLEN'(INSTR_BYTES);
    localparam logic [XLEN-1:0] PC_INIT  = XLEN'(RESET_PC);
    localparam logic [1:0]      CNT_LOAD = 2'(FLUSH_CYCLES - 1);

    logic [XLEN-1:0] r_pc;
    fetch_state_t    r_state, w_state_next;
    logic [1:0]      r_cnt, w_cnt_next;
    logic            r_flush, w_flush_next;
    logic            r_fetch_valid, w_fv_next;
    logic            r_started;

    logic            w_pend_valid;
    logic [XLEN-1:0] w_pend_target;
    logic            w_apply;
    logic            w_capture;
    logic [XLEN-1:0] w_raw_target;
    logic [XLEN-1:0] w_apply_target;

    // A live redirect outranks a pending one; both wait while stalled.
    assign w_apply      = !stall_in && (redirect_valid || w_pend_valid);
    assign w_capture    = stall_in && redirect_valid;
    assign w_raw_target = redirect_valid ? redirect_target : w_pend_target;

    pc_redirect_buf #(.XLEN(XLEN)) u_redirect_buf (
        .clk      (clk),
        .rst      (rst),
        .i_capture(w_capture),
        .i_clear  (w_apply),
        .i_target (redirect_target),
        .o_valid  (w_pend_valid),
        .o_target (w_pend_target)
    );

`ifdef PC_MISALIGN_CHECK_EN
    logic r_misalign;
    logic w_misalign;

    assign w_apply_target = {w_raw_target[XLEN-1:2], 2'b00};
    assign w_misalign     = w_apply && (w_raw_target[1:0] != 2'b00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= w_misalign;
        end
    end

    assign misalign_err = r_misalign;
`else
    assign w_apply_target = w_raw_target;
    assign misalign_err   = 1'b0;
`endif

    // The first edge out of reset re-fetches RESET_PC instead of advancing.
    always_comb begin
        if (w_apply) begin
            pc_next = w_apply_target;
        end else if (stall_in || !r_started) begin
            pc_next = r_pc;
        end else begin
            pc_next = r_pc + INCR;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc          <= PC_INIT;
            r_state       <= ST_RUN;
            r_cnt         <= 2'd0;
            r_flush       <= 1'b0;
            r_fetch_valid <= 1'b0;
            r_started     <= 1'b0;
        end else begin
            r_pc          <= pc_next;
            r_state       <= w_state_next;
            r_cnt         <= w_cnt_next;
            r_flush       <= w_flush_next;
            r_fetch_valid <= w_fv_next;
            r_started     <= 1'b1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        if (w_apply) begin
            w_state_next = ST_FLUSH;
            w_cnt_next   = CNT_LOAD;
        end else if (w_capture) begin
            w_state_next = ST_HOLD;
        end else begin
            case (r_state)
                ST_RUN:   w_state_next = ST_RUN;
                ST_FLUSH: begin
                    if (!stall_in) begin
                        if (r_cnt == 2'd0) begin
                            w_state_next = ST_RUN;
                        end else begin
                            w_cnt_next = r_cnt - 2'd1;
                        end
                    end
                end
                ST_HOLD:  w_state_next = ST_HOLD;
                default:  w_state_next = ST_RUN;
            endcase
        end
    end

    // Flush is frozen, not dropped, while a stall holds the counter.
    always_comb begin
        w_flush_next = r_flush;
        w_fv_next    = r_fetch_valid;
        if (w_apply) begin
            w_flush_next = 1'b1;
            w_fv_next    = 1'b0;
        end else if (!w_capture) begin
            case (r_state)
                ST_RUN: begin
                    w_flush_next = 1'b0;
                    w_fv_next    = 1'b1;
                end
                ST_FLUSH: begin
                    if (!stall_in && r_cnt == 2'd0) begin
                        w_flush_next = 1'b0;
                        w_fv_next    = 1'b1;
                    end
                end
                default: begin
                    w_flush_next = r_flush;
                    w_fv_next    = r_fetch_valid;
                end
            endcase
        end
    end

    assign pc_out           = r_pc;
    assign pc_stall         = stall_in;
    assign flush            = r_flush;
    assign fetch_valid      = r_fetch_valid;
    assign redirect_pending = w_pend_valid;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed scenarios then random traffic,
// compared against a cycle-level behavioural model of the fetch PC stream.
module tb_pc_fetch_ctrl;

    localparam int          FC      = 2;
    localparam logic [31:0] RST_PC  = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        stall_in;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] pc_out;
    logic [31:0] pc_next;
    logic        pc_stall;
    logic        flush;
    logic        fetch_valid;
    logic        redirect_pending;
    logic        misalign_err;

    int total;
    int bad;

    logic [31:0] m_pc;
    bit          m_started;
    int          m_left;
    bit          m_fv;
    bit          m_pend_v;
    logic [31:0] m_pend_t;
    bit          m_mis;

    pc_fetch_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .stall_in        (stall_in),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .pc_out          (pc_out),
        .pc_next         (pc_next),
        .pc_stall        (pc_stall),
        .flush           (flush),
        .fetch_valid     (fetch_valid),
        .redirect_pending(redirect_pending),
        .misalign_err    (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_align(input logic [31:0] t);
`ifdef PC_MISALIGN_CHECK_EN
        return t & 32'hFFFF_FFFC;
`else
        return t;
`endif
    endfunction

    function automatic bit model_mis(input logic [31:0] t);
`ifdef PC_MISALIGN_CHECK_EN
        return (t[1:0] != 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_pc      = RST_PC;
        m_started = 1'b0;
        m_left    = 0;
        m_fv      = 1'b0;
        m_pend_v  = 1'b0;
        m_pend_t  = 32'h0;
        m_mis     = 1'b0;
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".pc_out"}, pc_out, m_pc);
        check({tag, ".flush"}, {31'b0, flush}, {31'b0, (m_left > 0)});
        check({tag, ".fetch_valid"}, {31'b0, fetch_valid}, {31'b0, m_fv});
        check({tag, ".pending"}, {31'b0, redirect_pending}, {31'b0, m_pend_v});
        check({tag, ".misalign"}, {31'b0, misalign_err}, {31'b0, m_mis});
    endtask

    // One clock: drive inputs, check combinational outputs mid-cycle, advance model, check registers.
    task automatic step(input string tag, input bit s, input bit rv, input logic [31:0] rt);
        bit          apply;
        logic [31:0] tgt;
        logic [31:0] exp_next;
        stall_in        = s;
        redirect_valid  = rv;
        redirect_target = rt;
        @(negedge clk);
        apply = !s && (rv || m_pend_v);
        tgt   = rv ? rt : m_pend_t;
        if (apply) exp_next = model_align(tgt);
        else if (s || !m_started) exp_next = m_pc;
        else exp_next = m_pc + 32'd4;
        check({tag, ".pc_next"}, pc_next, exp_next);
        check({tag, ".pc_stall"}, {31'b0, pc_stall}, {31'b0, s});
        m_pc      = exp_next;
        m_started = 1'b1;
        if (apply) begin
            m_left   = FC;
            m_fv     = 1'b0;
            m_pend_v = 1'b0;
            m_mis    = model_mis(tgt);
        end else begin
            m_mis = 1'b0;
            if (s && rv) begin
                m_pend_v = 1'b1;
                m_pend_t = rt;
            end else if (!s) begin
                if (m_left > 0) begin
                    m_left--;
                    if (m_left == 0) m_fv = 1'b1;
                end else begin
                    m_fv = 1'b1;
                end
            end else if (!m_pend_v && m_left == 0) begin
                m_fv = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        check_regs(tag);
        $display("step %s stall=%0b rv=%0b tgt=%h pc_out=%h flush=%0b fv=%0b pend=%0b mis=%0b",
                 tag, s, rv, rt, pc_out, flush, fetch_valid, redirect_pending, misalign_err);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst             = 1'b1;
        stall_in        = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        model_reset();
        @(posedge clk);
        #1;
        check_regs("reset");
        rst = 1'b0;

        // Free-running start: PC repeats RESET_PC once, then advances.
        step("free0", 0, 0, 0);
        check("first_hold", pc_out, RST_PC);
        for (int i = 0; i < 4; i++) step("free", 0, 0, 0);
        check("reach_0x10", pc_out, 32'h10);

        step("redir100", 0, 1, 32'h100);
        check("redir_lat", pc_out, 32'h100);
        for (int i = 0; i < 3; i++) step("flush", 0, 0, 0);

        // Position PC at 0x20, then stall three cycles.
        step("redir18", 0, 1, 32'h18);
        step("to1c", 0, 0, 0);
        step("to20", 0, 0, 0);
        for (int i = 0; i < 3; i++) step("stall", 1, 0, 0);
        check("stall_hold", pc_out, 32'h20);
        step("release", 0, 0, 0);
        check("release_inc", pc_out, 32'h24);

        // Two redirects under stall: newest wins on release.
        step("hold0", 1, 0, 0);
        step("hold200", 1, 1, 32'h200);
        step("hold300", 1, 1, 32'h300);
        step("hold1", 1, 0, 0);
        step("apply_pend", 0, 0, 0);
        check("pend_target", pc_out, 32'h300);
        for (int i = 0; i < 3; i++) step("pflush", 0, 0, 0);

        // Live redirect beats a pending one on release.
        step("hold500", 1, 1, 32'h500);
        step("live600", 0, 1, 32'h600);
        check("live_wins", pc_out, 32'h600);
        step("after600", 0, 0, 0);

        // Address wrap at the top of the space.
        step("redir_top", 0, 1, 32'hFFFF_FFF4);
        step("top1", 0, 0, 0);
        step("top2", 0, 0, 0);
        step("wrap", 0, 0, 0);
        check("wrap_zero", pc_out, 32'h0);

        // Asynchronous reset in the middle of a flush.
        step("redir400", 0, 1, 32'h400);
        rst = 1'b1;
        #1;
        model_reset();
        check_regs("async_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        step("post_rst", 0, 0, 0);
        step("post_rst", 0, 0, 0);

        // Misaligned targets, live and pending.
        step("mis102", 0, 1, 32'h102);
`ifdef PC_MISALIGN_CHECK_EN
        check("mis_pc", pc_out, 32'h100);
        check("mis_flag", {31'b0, misalign_err}, 32'h1);
`else
        check("mis_pc", pc_out, 32'h102);
        check("mis_flag", {31'b0, misalign_err}, 32'h0);
`endif
        step("mis_after", 0, 0, 0);
        step("mis_hold", 1, 1, 32'h207);
        step("mis_apply", 0, 0, 0);
        step("mis_after2", 0, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            bit          rs;
            bit          rrv;
            logic [31:0] rt;
            rs  = ($urandom_range(0, 9) < 3);
            rrv = ($urandom_range(0, 7) == 0);
            rt  = $urandom;
            if ($urandom_range(0, 3) != 0) rt[1:0] = 2'b00;
            step("rand", rs, rrv, rt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
